uart_cmd_ctrl: RTL and testbench

Command sequencer sitting directly behind the UART receiver. It consumes received bytes (`data_valid`/`data_out`) and the inter-block `block_timeout` pulse, decodes them into write/read command packets, and drives a simple register bus. Read results go to the UART transmitter over a valid/ready handshake. Partial packets are aborted cleanly on block timeout.

---
 rtl/uart_cmd_ctrl.sv | 171 +++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : UART command sequencer. Decodes received write/read packets
//               into register-bus strobes and returns read data to the UART
//               transmitter. Optional macro UART_CMD_ADDR_INC_EN enables
//               address auto-increment (burst access); when it is undefined
//               the address is fixed for the whole packet.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_ctrl #(
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_block_timeout,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       busy,
  output logic       abort,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_WDATA   = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_TX_WAIT = 3'd5
  } state_t;

  // RD_WAIT is entered in the same cycle reg_rd_en is high, so the counter
  // starts at RD_LATENCY and the capture happens when it reaches zero.
  localparam logic [2:0] c_WAIT_LOAD = 3'(RD_LATENCY);

  state_t     r_state;
  logic       r_rw;
  logic [6:0] r_count;
  logic [7:0] r_addr;
  logic [2:0] r_wait;
  logic [7:0] w_addr_adv;
  logic       w_last;

`ifdef UART_CMD_ADDR_INC_EN
  assign w_addr_adv = r_addr + 8'd1;
`else
  assign w_addr_adv = r_addr;
`endif

  assign w_last = (r_count == 7'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rw      <= 1'b0;
      r_count   <= 7'd0;
      r_addr    <= 8'd0;
      r_wait    <= 3'd0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      reg_addr  <= 8'd0;
      reg_wdata <= 8'd0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'd0;
      busy      <= 1'b0;
      abort     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      abort     <= 1'b0;
      overrun   <= 1'b0;

      // Timeout outranks everything outside IDLE, including a same-cycle byte.
      if ((r_state != S_IDLE) && rx_block_timeout) begin
        r_state  <= S_IDLE;
        busy     <= 1'b0;
        abort    <= 1'b1;
        tx_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (rx_data_valid) begin
              r_rw    <= rx_data[7];
              r_count <= rx_data[6:0];
              if (rx_data[6:0] == 7'd0) begin
                abort <= 1'b1;
              end else begin
                r_state <= S_ADDR;
                busy    <= 1'b1;
              end
            end
          end

          S_ADDR: begin
            if (rx_data_valid) begin
              r_addr  <= rx_data;
              r_state <= r_rw ? S_RD_REQ : S_WDATA;
            end
          end

          S_WDATA: begin
            if (rx_data_valid) begin
              reg_wr_en <= 1'b1;
              reg_addr  <= r_addr;
              reg_wdata <= rx_data;
              r_addr    <= w_addr_adv;
              r_count   <= r_count - 7'd1;
              if (w_last) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
              end
            end
          end

          S_RD_REQ: begin
            overrun   <= rx_data_valid;
            reg_rd_en <= 1'b1;
            reg_addr  <= r_addr;
            r_wait    <= c_WAIT_LOAD;
            r_state   <= S_RD_WAIT;
          end

          S_RD_WAIT: begin
            overrun <= rx_data_valid;
            if (r_wait == 3'd0) begin
              tx_data  <= reg_rdata;
              tx_valid <= 1'b1;
              r_state  <= S_TX_WAIT;
            end else begin
              r_wait <= r_wait - 3'd1;
            end
          end

          S_TX_WAIT: begin
            overrun <= rx_data_valid;
            if (tx_ready) begin
              tx_valid <= 1'b0;
              r_addr   <= w_addr_adv;
              r_count  <= r_count - 7'd1;
              if (w_last) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
              end else begin
                r_state <= S_RD_REQ;
              end
            end
          end

          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Self-checking bench for uart_cmd_ctrl with a randomised
//               register-file model and packet-level expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_ctrl;

  localparam int LAT = 2;
`ifdef UART_CMD_ADDR_INC_EN
  localparam int STEP = 1;
`else
  localparam int STEP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_data_valid;
  logic [7:0] rx_data;
  logic       rx_block_timeout;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       abort;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  uart_cmd_ctrl #(.RD_LATENCY(LAT)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_data_valid    (rx_data_valid),
    .rx_data          (rx_data),
    .rx_block_timeout (rx_block_timeout),
    .reg_wr_en        (reg_wr_en),
    .reg_rd_en        (reg_rd_en),
    .reg_addr         (reg_addr),
    .reg_wdata        (reg_wdata),
    .reg_rdata        (reg_rdata),
    .tx_valid         (tx_valid),
    .tx_data          (tx_data),
    .tx_ready         (tx_ready),
    .busy             (busy),
    .abort            (abort),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: data appears exactly LAT cycles after the read strobe.
  logic [7:0] mem [256];
  logic [3:0] pv_rd = 4'd0;
  logic [7:0] pa_rd [4];
  always @(posedge clk) begin
    pv_rd    <= {pv_rd[2:0], reg_rd_en};
    pa_rd[0] <= reg_addr;
    pa_rd[1] <= pa_rd[0];
    pa_rd[2] <= pa_rd[1];
    pa_rd[3] <= pa_rd[2];
  end
  assign reg_rdata = pv_rd[LAT-1] ? mem[pa_rd[LAT-1]] : 8'hEE;

  // Bus and event log, sampled mid-cycle.
  logic [7:0] wr_a [$];
  logic [7:0] wr_d [$];
  logic [7:0] rd_a [$];
  int         rd_c [$];
  int         rise_c [$];
  int         n_abort = 0;
  int         n_overrun = 0;
  int         n_unstable = 0;
  logic       pv_valid = 1'b0;
  logic [7:0] pv_data = 8'd0;

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_a.push_back(reg_addr);
      wr_d.push_back(reg_wdata);
    end
    if (reg_rd_en) begin
      rd_a.push_back(reg_addr);
      rd_c.push_back(cyc);
    end
    if (tx_valid && !pv_valid) rise_c.push_back(cyc);
    if (tx_valid && pv_valid && (tx_data !== pv_data)) n_unstable++;
    if (abort) n_abort++;
    if (overrun) n_overrun++;
    pv_valid = tx_valid;
    pv_data  = tx_data;
  end

  logic [7:0] wq [$];

  function automatic logic [7:0] exp_addr(input logic [7:0] s, input int i);
    return s + 8'(STEP * i);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data_valid = 1'b1;
    rx_data       = b;
    @(negedge clk);
    rx_data_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_timeout();
    @(negedge clk);
    rx_block_timeout = 1'b1;
    @(negedge clk);
    rx_block_timeout = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Sends a write packet carrying the bytes in wq, then checks the bus log.
  task automatic do_write(input logic [7:0] start, input string tag);
    int wb, ab, n;
    wb = wr_a.size();
    ab = n_abort;
    n  = wq.size();
    send_byte({1'b0, 7'(n)}, 0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy after header: got %b want 1", tag, busy);
    end
    send_byte(start, $urandom_range(0, 2));
    for (int i = 0; i < n; i++) send_byte(wq[i], $urandom_range(0, 2));
    repeat (3) @(negedge clk);
    total++;
    if (wr_a.size() - wb !== n) begin
      bad++;
      $display("FAIL %s write count: got %0d want %0d", tag, wr_a.size() - wb, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        total++;
        if (wr_a[wb+i] !== exp_addr(start, i) || wr_d[wb+i] !== wq[i]) begin
          bad++;
          $display("FAIL %s write %0d: got %h/%h want %h/%h", tag, i,
                   wr_a[wb+i], wr_d[wb+i], exp_addr(start, i), wq[i]);
        end
      end
    end
    total++;
    if (busy !== 1'b0 || n_abort !== ab) begin
      bad++;
      $display("FAIL %s end state: got busy=%b aborts=%0d want busy=0 aborts=0",
               tag, busy, n_abort - ab);
    end
  endtask

  // Sends a read packet, holds tx_ready low for 'hold' cycles per byte.
  task automatic do_read(input logic [6:0] len, input logic [7:0] start,
                         input int hold, input string tag);
    int rb, cb, ub, ab;
    bit ok;
    logic [7:0] got [$];
    rb = rd_a.size();
    cb = rise_c.size();
    ub = n_unstable;
    ab = n_abort;
    send_byte({1'b1, len}, 0);
    send_byte(start, $urandom_range(0, 2));
    for (int i = 0; i < int'(len); i++) begin
      wait_valid(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s tx_valid byte %0d: got timeout want tx_valid", tag, i);
        return;
      end
      repeat (hold) @(negedge clk);
      tx_ready = 1'b1;
      got.push_back(tx_data);
      @(negedge clk);
      tx_ready = 1'b0;
    end
    repeat (3) @(negedge clk);
    total++;
    if (rd_a.size() - rb !== int'(len) || rise_c.size() - cb !== int'(len)) begin
      bad++;
      $display("FAIL %s read count: got rd=%0d rise=%0d want %0d", tag,
               rd_a.size() - rb, rise_c.size() - cb, len);
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        total++;
        if (rd_a[rb+i] !== exp_addr(start, i) || got[i] !== mem[exp_addr(start, i)]) begin
          bad++;
          $display("FAIL %s read %0d: got addr=%h data=%h want addr=%h data=%h", tag, i,
                   rd_a[rb+i], got[i], exp_addr(start, i), mem[exp_addr(start, i)]);
        end
        total++;
        if (rise_c[cb+i] - rd_c[rb+i] !== LAT + 1) begin
          bad++;
          $display("FAIL %s latency %0d: got %0d want %0d", tag, i,
                   rise_c[cb+i] - rd_c[rb+i], LAT + 1);
        end
      end
    end
    total++;
    if (n_unstable !== ub || busy !== 1'b0 || n_abort !== ab) begin
      bad++;
      $display("FAIL %s end state: got unstable=%0d busy=%b aborts=%0d want 0/0/0",
               tag, n_unstable - ub, busy, n_abort - ab);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_data_valid = 1'b0;
    rx_data = 8'd0;
    rx_block_timeout = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({reg_wr_en, reg_rd_en, reg_addr, reg_wdata, tx_valid, busy, abort, overrun} !== 22'd0) begin
      bad++;
      $display("FAIL reset outputs: got %b want all zero",
               {reg_wr_en, reg_rd_en, reg_addr, reg_wdata, tx_valid, busy, abort, overrun});
    end
    total++;
    if (tx_data !== 8'd0) begin
      bad++;
      $display("FAIL reset tx_data: got %h want 00", tx_data);
    end
  endtask

  task automatic test_write();
    wq.delete();
    wq.push_back(8'hAA);
    wq.push_back(8'hBB);
    wq.push_back(8'hCC);
    do_write(8'h10, "write_basic");
    for (int p = 0; p < 4; p++) begin
      wq.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) wq.push_back(8'($urandom));
      do_write(($urandom_range(0, 1) == 1) ? 8'hFD : 8'($urandom), "write_rand");
    end
  endtask

  task automatic test_read();
    do_read(7'd2, 8'hFF, 5, "read_wrap");
    for (int p = 0; p < 3; p++)
      do_read(7'($urandom_range(1, 4)), 8'($urandom), $urandom_range(0, 3), "read_rand");
  endtask

  task automatic test_abort();
    int wb, ab, ob;
    wb = wr_a.size();
    ab = n_abort;
    ob = n_overrun;
    send_byte(8'h04, 0);
    send_byte(8'h20, 1);
    send_byte(8'h01, 0);
    pulse_timeout();
    repeat (3) @(negedge clk);
    total++;
    if (wr_a.size() - wb !== 1) begin
      bad++;
      $display("FAIL abort write count: got %0d want 1", wr_a.size() - wb);
    end else begin
      total++;
      if (wr_a[wb] !== 8'h20 || wr_d[wb] !== 8'h01) begin
        bad++;
        $display("FAIL abort write: got %h/%h want 20/01", wr_a[wb], wr_d[wb]);
      end
    end
    total++;
    if (n_abort - ab !== 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort pulse: got aborts=%0d busy=%b want 1/0", n_abort - ab, busy);
    end
    pulse_timeout();
    repeat (2) @(negedge clk);
    total++;
    if (n_abort - ab !== 1) begin
      bad++;
      $display("FAIL idle timeout: got aborts=%0d want 1", n_abort - ab);
    end
    send_byte(8'h02, 0);
    send_byte(8'h60, 0);
    @(negedge clk);
    rx_data_valid = 1'b1;
    rx_data = 8'h77;
    rx_block_timeout = 1'b1;
    @(negedge clk);
    rx_data_valid = 1'b0;
    rx_block_timeout = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (wr_a.size() - wb !== 1 || n_abort - ab !== 2 || n_overrun !== ob || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_vs_byte: got writes=%0d aborts=%0d overruns=%0d busy=%b want 1/2/0/0",
               wr_a.size() - wb, n_abort - ab, n_overrun - ob, busy);
    end
    wq.delete();
    wq.push_back(8'h55);
    do_write(8'h30, "after_abort");
  endtask

  task automatic test_zero_overrun();
    int wb, rb, ab, ob;
    bit ok;
    logic [7:0] got;
    wb = wr_a.size();
    rb = rd_a.size();
    ab = n_abort;
    send_byte(8'h00, 2);
    total++;
    if (n_abort - ab !== 1 || wr_a.size() !== wb || rd_a.size() !== rb || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_len: got aborts=%0d wr=%0d rd=%0d busy=%b want 1/0/0/0",
               n_abort - ab, wr_a.size() - wb, rd_a.size() - rb, busy);
    end
    ob = n_overrun;
    send_byte(8'h81, 0);
    send_byte(8'h05, 0);
    wait_valid(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL overrun tx_valid: got timeout want tx_valid");
      return;
    end
    @(negedge clk);
    rx_data_valid = 1'b1;
    rx_data = 8'h99;
    @(negedge clk);
    rx_data_valid = 1'b0;
    repeat (2) @(negedge clk);
    tx_ready = 1'b1;
    got = tx_data;
    @(negedge clk);
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (n_overrun - ob !== 1) begin
      bad++;
      $display("FAIL overrun pulses: got %0d want 1", n_overrun - ob);
    end
    total++;
    if (rd_a.size() - rb !== 1 || got !== mem[8'h05] || busy !== 1'b0 || n_abort - ab !== 1) begin
      bad++;
      $display("FAIL overrun read: got rd=%0d data=%h busy=%b want 1/%h/0",
               rd_a.size() - rb, got, busy, mem[8'h05]);
    end
  endtask

  task automatic test_reset_mid();
    int ab;
    bit ok;
    ab = n_abort;
    send_byte(8'h81, 0);
    send_byte(8'h40, 0);
    wait_valid(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL reset_mid tx_valid: got timeout want tx_valid");
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'd0 || reg_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid async: got valid=%b busy=%b data=%h rd=%b want 0/0/00/0",
               tx_valid, busy, tx_data, reg_rd_en);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (n_abort !== ab) begin
      bad++;
      $display("FAIL reset_mid abort: got %0d want 0", n_abort - ab);
    end
    wq.delete();
    wq.push_back(8'h11);
    wq.push_back(8'h22);
    do_write(8'h50, "after_reset");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_zero_overrun();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
